dmem_resp: RTL
==============

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the byte-address bits used; memory depth is 2^(ADDR_W-2) 32-bit words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted before each access; legal range is 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port req, input, 1 bit: request valid, held by the requester until ack.
REQ-006 The block SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port funct3, input, 3 bits: RISC-V width code.
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
REQ-008 The block SHALL have port addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port rdata, output, 32 bits: load result, extended to 32 bits.
REQ-011 The block SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1 bit: error flag, valid only while ack=1.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, WAIT, ACCESS, RESP.
REQ-015 In IDLE with req=1, the block SHALL do both of the following at that edge:
- latch we, funct3, addr and wdata;
- go to WAIT with the counter loaded to WAIT_CYCLES, or go straight to ACCESS if WAIT_CYCLES=0.
REQ-016 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to ACCESS on the edge where the counter equals 1.
REQ-017 In ACCESS, the block SHALL perform the memory read or write (one cycle) and then go to RESP.
REQ-018 In RESP, ack SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-019 Latency for a valid request SHALL be exactly WAIT_CYCLES+2 cycles from the accepting edge to the cycle in which ack is high.
REQ-020 A request SHALL be flagged as an error when either condition holds:
- misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00;
- illegal funct3: a load code outside REQ-007, or a store code above 010.
REQ-021 An error request SHALL go IDLE->RESP directly, with ack=1 and err=1 one cycle after acceptance; memory and rdata SHALL remain unchanged.
REQ-022 Inputs SHALL be sampled only at acceptance; later changes before ack SHALL be ignored.
REQ-023 If req is still high in the RESP cycle, it SHALL NOT be accepted; the earliest next acceptance is in the IDLE cycle that follows (one idle cycle minimum between requests).
REQ-024 Word address SHALL be addr[ADDR_W-1:2]; upper address bits SHALL be ignored, so addresses wrap modulo the depth.
REQ-025 Stores SHALL write only the addressed byte lanes:
- SB: lane addr[1:0];
- SH: lanes addr[1]*2 and addr[1]*2+1;
- SW: all four lanes.
REQ-026 Loads SHALL select the addressed byte or halfword; LB and LH SHALL sign-extend, and LBU and LHU SHALL zero-extend.
REQ-027 rdata SHALL update only in a load's ACCESS→RESP transition and SHALL hold its value otherwise, including across stores and errors.
REQ-028 err SHALL be 0 whenever ack is 0.

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously force: state IDLE, counter 0, ack 0, err 0, busy 0, rdata 0x00000000.
REQ-030 Reset mid-operation SHALL abort the request with no ack; a store not yet in ACCESS SHALL NOT be written.
REQ-031 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-032 A shared package SHALL hold the funct3 load/store constants and the FSM state encoding.
REQ-033 The RAM SHALL be a sub-module, dmem_ram, with these properties:
- synchronous read and write;
- 4-bit byte-lane write enable;
- depth 2^(ADDR_W-2);
- no reset.

Verification
REQ-034 With WAIT_CYCLES=2: SW addr=0x10, wdata=0xDEADBEEF, then LW addr=0x10 -> each ack arrives exactly 4 cycles after acceptance, and rdata=0xDEADBEEF.
REQ-035 After the 0x10 word holds 0xDEADBEEF: SB addr=0x11, wdata=0x80 -> word becomes 0xDEAD80EF; then LB 0x11 -> rdata=0xFFFFFF80, and LBU 0x11 -> rdata=0x00000080.
REQ-036 LH addr=0x13 -> ack with err=1 one cycle after acceptance, rdata unchanged; then SW addr=0x2 -> err=1 and memory unchanged.
REQ-037 With ADDR_W=10: SW addr=0x400, wdata=0x12345678, then LW addr=0x0 -> rdata=0x12345678 (wrap).
REQ-038 SW addr=0x20 with rst_n pulsed low during WAIT -> no ack, busy=0 immediately; then LW 0x20 -> prior contents returned.
REQ-039 req held high continuously for back-to-back LW -> ack pulses spaced WAIT_CYCLES+3 cycles apart, never two consecutive cycles.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: funct3 width codes,
// FSM state encoding and request-legality helpers.
package dmem_resp_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > F3_W);
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  // Width is carried in funct3[1:0] for every legal code.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// Word-wide RAM with byte-lane write enables, synchronous read and write, no reset.
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-3:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1 << (ADDR_W-2))-1];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder: accepts one load/store, inserts wait
// states, performs a byte-lane access and returns a one-cycle ack.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  state_t state, nxt;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [2:0]        lat_f3;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic              err_q;
  logic              bad;
  logic              accept;

  logic [ADDR_W-3:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;
  logic [31:0]       load_val;
  logic              unused_addr;

  assign unused_addr = ^addr[31:ADDR_W];

  assign bad    = f3_illegal(we, funct3) || misaligned(funct3, addr[1:0]);
  assign accept = (state == IDLE) && req;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (bad)                   nxt = RESP;
          else if (WAIT_CYCLES == 0) nxt = ACCESS;
          else                       nxt = WAIT;
        end
      end
      WAIT:    if (cnt == 4'd1) nxt = ACCESS;
      ACCESS:  nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      err_q     <= 1'b0;
      rdata     <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        lat_we    <= we;
        lat_f3    <= funct3;
        lat_addr  <= addr[ADDR_W-1:0];
        lat_wdata <= wdata;
        err_q     <= bad;
        cnt       <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if ((state == ACCESS) && !lat_we) rdata <= load_val;
    end
  end

  // Read address follows the live input while idle so the RAM output is
  // already valid in ACCESS even when there are no wait states.
  assign ram_addr = (state == IDLE) ? addr[ADDR_W-1:2] : lat_addr[ADDR_W-1:2];

  always_comb begin
    ram_be    = '0;
    ram_wdata = lat_wdata;
    unique case (lat_f3[1:0])
      2'b00: begin
        ram_wdata = {4{lat_wdata[7:0]}};
        ram_be    = 4'b0001 << lat_addr[1:0];
      end
      2'b01: begin
        ram_wdata = {2{lat_wdata[15:0]}};
        ram_be    = lat_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ram_be = 4'b1111;
    endcase
    if (!((state == ACCESS) && lat_we)) ram_be = '0;
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = ram_q[8*lat_addr[1:0] +: 8];
    h = lat_addr[1] ? ram_q[31:16] : ram_q[15:0];
    load_val = ram_q;
    unique case (lat_f3)
      F3_B:    load_val = {{24{b[7]}}, b};
      F3_BU:   load_val = {24'd0, b};
      F3_H:    load_val = {{16{h[15]}}, h};
      F3_HU:   load_val = {16'd0, h};
      default: load_val = ram_q;
    endcase
  end

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  assign ack  = (state == RESP);
  assign err  = ack && err_q;
  assign busy = (state != IDLE);

endmodule
